debounce_event_arbiter: RTL and testbench

//  Shares one sample-rate prescaler across p_CHANNELS debounce filters. Raw, bouncing button/switch inputs become

---
 rtl/debounce_event_arbiter_pkg.sv | 16 +
 rtl/debounce_event_arbiter_channel.sv | 84 ++++++++
 rtl/debounce_event_arbiter.sv | 104 ++++++++++
 tb/tb_debounce_event_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_event_arbiter_pkg.sv
// Shared definitions for the debounce/event arbiter: event encoding and index-width helper.
package debounce_event_arbiter_pkg;

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_HOLD = 1'b1
  } evt_state_e;

  localparam int unsigned EVT_PRESS_W = 1;

  // Index width for n items, never below one bit so single-entry ranges stay legal.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_event_arbiter_channel.sv
// One debounce lane: 2-flop synchronizer, tick-driven stability filter and a single pending-event slot.
module debounce_event_arbiter_channel
  import debounce_event_arbiter_pkg::*;
#(
  parameter int unsigned p_CNT_WIDTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  input  logic grant_i,
  output logic level_o,
  output logic pend_o,
  output logic pol_o,
  output logic ovr_set_o
);

  logic                   sync1_q, sync2_q;
  logic                   level_q, level_d;
  logic [p_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   strobe_q, strobe_d;
  logic                   pend_q, pend_d;
  logic [EVT_PRESS_W-1:0] pol_q, pol_d;

  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == '1) begin
        level_d  = sync2_q;
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + p_CNT_WIDTH'(1);
      end
    end
  end

  // A second change before the first was granted cancels the pair instead of queueing it.
  assign ovr_set_o = strobe_q & pend_q & ~grant_i;

  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    if (strobe_q) begin
      if (pend_q && !grant_i) begin
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
        pol_d  = level_q;
      end
    end else if (grant_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      pend_q   <= 1'b0;
      pol_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      pend_q   <= pend_d;
      pol_q    <= pol_d;
    end
  end

  assign level_o = level_q;
  assign pend_o  = pend_q;
  assign pol_o   = pol_q;

endmodule

// File: rtl/debounce_event_arbiter.sv
// Shared prescaler, per-channel debounce lanes, round-robin arbiter and a valid/ready event register.
module debounce_event_arbiter
  import debounce_event_arbiter_pkg::*;
#(
  parameter int unsigned p_CHANNELS  = 4,
  parameter int unsigned p_CNT_WIDTH = 2,
  parameter int unsigned p_DIV       = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [p_CHANNELS-1:0]               i_raw,
  output logic [p_CHANNELS-1:0]               o_level,
  output logic                                o_evt_valid,
  input  logic                                i_evt_ready,
  output logic [ch_idx_w(p_CHANNELS)-1:0]     o_evt_ch,
  output logic                                o_evt_press,
  output logic [p_CHANNELS-1:0]               o_overrun,
  input  logic                                i_ovr_clr
);

  localparam int unsigned CH_W  = ch_idx_w(p_CHANNELS);
  localparam int unsigned DIV_W = ch_idx_w(p_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(p_DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(p_CHANNELS - 1);

  evt_state_e             state_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   tick;
  logic [CH_W-1:0]        rr_q, rr_d;
  logic [CH_W-1:0]        ch_q;
  logic                   press_q;
  logic [p_CHANNELS-1:0]  ovr_q;
  logic [p_CHANNELS-1:0]  pend, pol, ovr_set, grant;
  logic                   free, found;
  logic [CH_W-1:0]        win;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  for (genvar g = 0; g < p_CHANNELS; g++) begin : g_ch
    debounce_event_arbiter_channel #(
      .p_CNT_WIDTH(p_CNT_WIDTH)
    ) u_ch (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .tick_i   (tick),
      .raw_i    (i_raw[g]),
      .grant_i  (grant[g]),
      .level_o  (o_level[g]),
      .pend_o   (pend[g]),
      .pol_o    (pol[g]),
      .ovr_set_o(ovr_set[g])
    );
  end

  assign free = (state_q == EVT_IDLE) || i_evt_ready;

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    grant = '0;
    for (int unsigned i = 0; i < p_CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % p_CHANNELS;
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
    if (free && found) grant[win] = 1'b1;
    rr_d = (win == CH_LAST) ? '0 : win + CH_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EVT_IDLE;
      div_q   <= '0;
      rr_q    <= '0;
      ch_q    <= '0;
      press_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      div_q <= div_d;
      // New overrun set wins over a clear landing in the same cycle.
      ovr_q <= (i_ovr_clr ? '0 : ovr_q) | ovr_set;
      if (free) begin
        if (found) begin
          state_q <= EVT_HOLD;
          ch_q    <= win;
          press_q <= pol[win];
          rr_q    <= rr_d;
        end else begin
          state_q <= EVT_IDLE;
        end
      end
    end
  end

  assign o_evt_valid = (state_q == EVT_HOLD);
  assign o_evt_ch    = ch_q;
  assign o_evt_press = press_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Directed bench for debounce_event_arbiter: steady-state vector table plus timing-sensitive sequences.
module tb_debounce_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] raw = 4'hF;
  logic [3:0] level, ovr;
  logic       valid, press;
  logic [1:0] ch;

  int checks = 0;
  int errors = 0;
  logic [2:0] evq[$];

  typedef struct {
    logic [3:0]  raw;
    logic        rdy;
    logic        clr;
    int unsigned wait_n;
    logic [3:0]  e_level;
    logic        e_valid;
    logic [1:0]  e_ch;
    logic        e_press;
    logic [3:0]  e_ovr;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  debounce_event_arbiter #(
    .p_CHANNELS (4),
    .p_CNT_WIDTH(2),
    .p_DIV      (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_raw      (raw),
    .o_level    (level),
    .o_evt_valid(valid),
    .i_evt_ready(rdy),
    .o_evt_ch   (ch),
    .o_evt_press(press),
    .o_overrun  (ovr),
    .i_ovr_clr  (clr)
  );

  always @(posedge clk) begin
    if (!rst && valid && rdy) evq.push_back({ch, press});
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst = 1'b1;
    raw = r;
    rdy = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    evq.delete();
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    while (!valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk(name, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    int cnt;
    int lat;
    logic seen;
    logic [2:0] e;

    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 40, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000};
    tbl[1]  = '{4'b0011, 1'b0, 1'b0, 40, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0000};
    tbl[2]  = '{4'b0001, 1'b0, 1'b0, 40, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0010};
    tbl[3]  = '{4'b0001, 1'b0, 1'b1,  1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0000};
    tbl[4]  = '{4'b0001, 1'b1, 1'b0,  3, 4'b0001, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1001, 1'b0, 1'b0, 40, 4'b1001, 1'b1, 2'd3, 1'b1, 4'b0000};
    tbl[6]  = '{4'b1000, 1'b0, 1'b0, 40, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b0000};
    tbl[7]  = '{4'b1000, 1'b1, 1'b0,  1, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0000};
    tbl[8]  = '{4'b1000, 1'b0, 1'b0,  5, 4'b1000, 1'b1, 2'd0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0,  2, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 40, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000};
    tbl[11] = '{4'b0000, 1'b1, 1'b0,  2, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};

    // Reset held with all inputs high, then all four presses in channel order.
    repeat (4) @(negedge clk);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ch", {30'd0, ch}, 32'd0);
    chk("rst_press", {31'd0, press}, 32'd0);
    chk("rst_overrun", {28'd0, ovr}, 32'd0);
    rst = 1'b0;
    rdy = 1'b1;
    repeat (40) @(negedge clk);
    chk("t1_level", {28'd0, level}, 32'hF);
    chk("t1_count", evq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < evq.size()) begin
        e = {i[1:0], 1'b1};
        chk($sformatf("t1_event%0d", i), {29'd0, evq[i]}, {29'd0, e});
      end
    end

    // Bounce every 8 clocks never survives the filter.
    do_reset(4'h0);
    rdy = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (c % 8 == 0) raw[1] = ~raw[1];
      @(negedge clk);
      if (level !== 4'h0 || valid !== 1'b0) cnt++;
    end
    raw = 4'h0;
    repeat (20) @(negedge clk);
    chk("t2_watchdog", cnt, 32'd0);
    chk("t2_events", evq.size(), 32'd0);

    // Stable change on ch2: prescaler phase is known, so level rises exactly 16 clocks later.
    do_reset(4'h0);
    rdy = 1'b1;
    raw[2] = 1'b1;
    lat = 0;
    while (level[2] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_level_rise", {31'd0, level[2]}, 32'd1);
    chk("t3_latency", lat, 32'd16);
    repeat (30) @(negedge clk);
    chk("t3_count", evq.size(), 32'd1);
    if (evq.size() > 0) chk("t3_event", {29'd0, evq[0]}, 32'b101);

    // Backpressure with simultaneous ch0/ch3 presses from rr=0.
    do_reset(4'h0);
    raw = 4'b1001;
    wait_valid("t4_valid");
    chk("t4_first_ch", {30'd0, ch}, 32'd0);
    chk("t4_first_press", {31'd0, press}, 32'd1);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (valid !== 1'b1 || ch !== 2'd0 || press !== 1'b1) cnt++;
    end
    chk("t4_hold_stable", cnt, 32'd0);
    rdy = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_count", evq.size(), 32'd2);
    if (evq.size() == 2) begin
      chk("t4_order0", {29'd0, evq[0]}, 32'b001);
      chk("t4_order1", {29'd0, evq[1]}, 32'b111);
    end

    // Same race with rr=1: ch3 press must precede ch0 release.
    do_reset(4'h0);
    rdy = 1'b1;
    raw = 4'b0001;
    repeat (30) @(negedge clk);
    chk("t4b_prime", evq.size(), 32'd1);
    evq.delete();
    rdy = 1'b0;
    raw = 4'b1000;
    wait_valid("t4b_valid");
    chk("t4b_first_ch", {30'd0, ch}, 32'd3);
    rdy = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4b_count", evq.size(), 32'd2);
    if (evq.size() == 2) begin
      chk("t4b_order0", {29'd0, evq[0]}, 32'b111);
      chk("t4b_order1", {29'd0, evq[1]}, 32'b000);
    end

    // Steady-state table: overrun cancel, clear, handshakes and polarity.
    do_reset(4'h0);
    for (int i = 0; i < 12; i++) begin
      raw = tbl[i].raw;
      rdy = tbl[i].rdy;
      clr = tbl[i].clr;
      repeat (tbl[i].wait_n) @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_level", i), {28'd0, level}, {28'd0, tbl[i].e_level});
      chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_overrun", i), {28'd0, ovr}, {28'd0, tbl[i].e_ovr});
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_ch", i), {30'd0, ch}, {30'd0, tbl[i].e_ch});
        chk($sformatf("tbl%0d_press", i), {31'd0, press}, {31'd0, tbl[i].e_press});
      end
    end
    clr = 1'b0;

    // Overrun set must win over a clear held high throughout.
    do_reset(4'h0);
    raw = 4'b0001;
    repeat (40) @(negedge clk);
    clr = 1'b1;
    raw = 4'b0011;
    repeat (40) @(negedge clk);
    raw = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ovr[1] === 1'b1) seen = 1'b1;
    end
    chk("ovr_set_beats_clr", {31'd0, seen}, 32'd1);
    chk("ovr_cleared_after", {28'd0, ovr}, 32'd0);
    clr = 1'b0;

    // Asynchronous reset between edges while an event is held.
    do_reset(4'h0);
    raw = 4'b0100;
    wait_valid("t6_valid");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, valid}, 32'd0);
    chk("t6_async_level", {28'd0, level}, 32'd0);
    raw = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    evq.delete();
    rdy = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_stale", evq.size(), 32'd0);
    chk("t6_valid_low", {31'd0, valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
